fpumuls_retire: RTL and testbench

Retire stage directly downstream of the single-precision multiplier (`fpumuls`). It tracks each issued operation's tag through the multiplier's fixed, non-stallable latency and catches the 33-bit result and 11-bit raise vector in a small FIFO. It presents them to writeback over a valid/ready handshake and accumulates sticky exception flags. It also gates issue with a credit check, so a stalled writeback never loses a multiplier result.

---
 rtl/fpu_retire_pkg.sv | 23 ++
 rtl/fpu_tag_delay.sv | 49 ++++
 rtl/fpumuls_retire.sv | 120 ++++++++++++
 tb/tb_fpumuls_retire.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_retire_pkg.sv
// Shared defaults and entry layout for the multiplier retire stage.
// Raise-bit indices of the multiplier's raise vector.
package fpu_retire_pkg;

  localparam int unsigned Lat    = 2;
  localparam int unsigned Depth  = 4;
  localparam int unsigned TagW   = 6;
  localparam int unsigned ResW   = 33;
  localparam int unsigned RaiseW = 11;

  localparam int unsigned ExcInexact = 0;
  localparam int unsigned ExcUnder   = 1;
  localparam int unsigned ExcOver    = 2;
  localparam int unsigned ExcDivZero = 3;
  localparam int unsigned ExcInvalid = 4;

  typedef struct packed {
    logic [ResW-1:0]   res;
    logic [TagW-1:0]   tag;
    logic [RaiseW-1:0] raise;
  } fifo_entry_t;

endpackage

// File: rtl/fpu_tag_delay.sv
// LAT-stage {vld, tag} shift register mirroring the multiplier pipeline depth.
module fpu_tag_delay #(
  parameter int unsigned LAT   = 2,
  parameter int unsigned TAG_W = 6
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_vld,
  input  logic [TAG_W-1:0]           in_tag,
  output logic                       cap,
  output logic [TAG_W-1:0]           cap_tag,
  output logic [$clog2(LAT+1)-1:0]   inflight
);

  localparam int unsigned IW = $clog2(LAT + 1);

  logic [LAT-1:0]   vld_q;
  logic [TAG_W-1:0] tag_q [LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= in_vld;
      for (int i = 1; i < int'(LAT); i++) begin
        vld_q[i] <= vld_q[i-1];
      end
    end
  end

  // Tags are qualified by vld, so they need no reset.
  always_ff @(posedge clk) begin
    tag_q[0] <= in_tag;
    for (int i = 1; i < int'(LAT); i++) begin
      tag_q[i] <= tag_q[i-1];
    end
  end

  always_comb begin
    inflight = '0;
    for (int i = 0; i < int'(LAT); i++) begin
      inflight = inflight + IW'(vld_q[i]);
    end
  end

  assign cap     = vld_q[LAT-1];
  assign cap_tag = tag_q[LAT-1];

endmodule

// File: rtl/fpumuls_retire.sv
// Retire stage for fpumuls: tag tracking, result FIFO with issue credit,
// writeback handshake and sticky exception flags.
module fpumuls_retire
  import fpu_retire_pkg::*;
#(
  parameter int unsigned LAT   = Lat,
  parameter int unsigned DEPTH = Depth,
  parameter int unsigned TAG_W = TagW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             iss_en,
  input  logic [TAG_W-1:0] iss_tag,
  output logic             iss_ok,
  input  logic [32:0]      mul_res,
  input  logic [10:0]      mul_raise,
  input  logic [10:0]      exc_mask,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [32:0]      out_res,
  output logic [TAG_W-1:0] out_tag,
  output logic [10:0]      out_raise,
  output logic             out_trap,
  output logic [10:0]      sticky,
  input  logic             sticky_clr,
  output logic             err_ovf
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned IW = $clog2(LAT + 1);
  localparam int unsigned SW = ((CW > IW) ? CW : IW) + 1;

  typedef struct packed {
    logic [32:0]      res;
    logic [TAG_W-1:0] tag;
    logic [10:0]      raise;
  } entry_t;

  // All state moves on the multiplier's active edge.
  logic clk_act;
`ifdef swapedge
  assign clk_act = clk;
`else
  assign clk_act = ~clk;
`endif

  entry_t           mem_q [DEPTH];
  entry_t           head;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [10:0]      sticky_q, sticky_d;
  logic             err_q, err_d;
  logic             cap;
  logic [TAG_W-1:0] cap_tag;
  logic [IW-1:0]    inflight;
  logic [SW-1:0]    credit;
  logic             full, pop, push;

  fpu_tag_delay #(
    .LAT   (LAT),
    .TAG_W (TAG_W)
  ) u_tag_delay (
    .clk      (clk_act),
    .rst      (rst),
    .in_vld   (iss_en & iss_ok),
    .in_tag   (iss_tag),
    .cap      (cap),
    .cap_tag  (cap_tag),
    .inflight (inflight)
  );

  always_comb begin
    credit   = SW'(cnt_q) + SW'(inflight);
    iss_ok   = credit < SW'(DEPTH);
    out_vld  = cnt_q != '0;
    full     = cnt_q == CW'(DEPTH);
    pop      = out_vld & out_rdy;
    // A push at full only lands if the head leaves in the same cycle.
    push     = cap & (~full | pop);
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    cnt_d    = cnt_q + CW'(push) - CW'(pop);
    sticky_d = (sticky_clr ? 11'd0 : sticky_q) | (cap ? mul_raise : 11'd0);
    err_d    = err_q | (iss_en & ~iss_ok) | (cap & full & ~pop);
  end

  always_ff @(posedge clk_act) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      sticky_q <= '0;
      err_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
      err_q    <= err_d;
    end
  end

  always_ff @(posedge clk_act) begin
    if (!rst && push) begin
      mem_q[wr_ptr_q] <= '{res: mul_res, tag: cap_tag, raise: mul_raise};
    end
  end

  always_comb begin
    head      = mem_q[rd_ptr_q];
    out_res   = out_vld ? head.res : '0;
    out_tag   = out_vld ? head.tag : '0;
    out_raise = out_vld ? head.raise : '0;
    out_trap  = out_vld & |(head.raise & exc_mask);
    sticky    = sticky_q;
    err_ovf   = err_q;
  end

endmodule

// File: tb/tb_fpumuls_retire.sv
// Directed bench for fpumuls_retire: queue-based reference model checked every
// cycle, plus literal expectations per scenario.
module tb_fpumuls_retire;
  import fpu_retire_pkg::*;

  localparam int LAT   = 2;
  localparam int DEPTH = 4;
  localparam int TAG_W = 6;

  logic             clk = 1'b0;
  logic             clk_act;
  logic             rst, iss_en, iss_ok, out_vld, out_rdy, out_trap, sticky_clr, err_ovf;
  logic [TAG_W-1:0] iss_tag, out_tag;
  logic [32:0]      mul_res, out_res;
  logic [10:0]      mul_raise, exc_mask, out_raise, sticky;

  always #5 clk = ~clk;
`ifdef swapedge
  assign clk_act = clk;
`else
  assign clk_act = ~clk;
`endif

  fpumuls_retire #(
    .LAT   (LAT),
    .DEPTH (DEPTH),
    .TAG_W (TAG_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .iss_en     (iss_en),
    .iss_tag    (iss_tag),
    .iss_ok     (iss_ok),
    .mul_res    (mul_res),
    .mul_raise  (mul_raise),
    .exc_mask   (exc_mask),
    .out_vld    (out_vld),
    .out_rdy    (out_rdy),
    .out_res    (out_res),
    .out_tag    (out_tag),
    .out_raise  (out_raise),
    .out_trap   (out_trap),
    .sticky     (sticky),
    .sticky_clr (sticky_clr),
    .err_ovf    (err_ovf)
  );

  typedef struct {int tag; int cap_cyc;} fl_t;
  typedef struct {logic [32:0] res; int tag; logic [10:0] raise;} ent_t;

  fl_t         m_fl[$];
  ent_t        m_q[$];
  logic [10:0] m_sticky;
  bit          m_err;
  int          cyc;
  logic [32:0] res_tab [64];
  logic [10:0] raise_tab [64];
  int          passed, total;
  int          log_tag[$];
  logic [32:0] log_res[$];
  bit          seen_ok_low, started;
  int          first_vld_cyc;

  function automatic bit m_ok();
    return (m_q.size() + m_fl.size()) < DEPTH;
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // One active edge: drive multiplier outputs, advance DUT and model together.
  task automatic cycle();
    bit   cap, ok, pop;
    fl_t  fl;
    ent_t dropped;
    cap = (m_fl.size() > 0) && (m_fl[0].cap_cyc == cyc);
    if (cap) begin
      mul_res   = res_tab[m_fl[0].tag];
      mul_raise = raise_tab[m_fl[0].tag];
    end else begin
      mul_res   = {$urandom, 1'b1};
      mul_raise = 11'($urandom) | 11'h1;
    end
    ok  = m_ok();
    pop = (m_q.size() > 0) && out_rdy;
    @(posedge clk_act);
    if (rst) begin
      m_fl.delete();
      m_q.delete();
      m_sticky = '0;
      m_err    = 1'b0;
    end else begin
      if (iss_en && !ok) m_err = 1'b1;
      m_sticky = (sticky_clr ? 11'd0 : m_sticky) | (cap ? mul_raise : 11'd0);
      if (pop) dropped = m_q.pop_front();
      if (cap) begin
        fl = m_fl.pop_front();
        if (m_q.size() < DEPTH) m_q.push_back('{mul_res, fl.tag, mul_raise});
        else m_err = 1'b1;
      end
      if (iss_en && ok) m_fl.push_back('{int'(iss_tag), cyc + LAT});
    end
    cyc++;
    #1;
  endtask

  task automatic drive(input bit en, input int tag, input bit rdy);
    iss_en  = en;
    iss_tag = TAG_W'(tag);
    out_rdy = rdy;
    cycle();
  endtask

  always @(negedge clk_act) begin
    if (started) begin
      check("iss_ok", iss_ok, m_ok());
      check("out_vld", out_vld, m_q.size() > 0);
      check("sticky", sticky, m_sticky);
      check("err_ovf", err_ovf, m_err);
      if (m_q.size() > 0) begin
        check("out_res", out_res, m_q[0].res);
        check("out_tag", out_tag, m_q[0].tag);
        check("out_raise", out_raise, m_q[0].raise);
        check("out_trap", out_trap, |(m_q[0].raise & exc_mask));
      end else begin
        check("out_trap_idle", out_trap, 0);
      end
      if (!iss_ok) seen_ok_low = 1'b1;
      if (out_vld && first_vld_cyc < 0) first_vld_cyc = cyc;
      if (out_vld && out_rdy && !rst) begin
        log_tag.push_back(int'(out_tag));
        log_res.push_back(out_res);
      end
    end
  end

  initial begin
    int iss0, acc, hits;
    rst = 1'b1; iss_en = 1'b0; iss_tag = '0; out_rdy = 1'b0; sticky_clr = 1'b0;
    exc_mask = '0; mul_res = '0; mul_raise = '0;
    passed = 0; total = 0; cyc = 0; m_sticky = '0; m_err = 1'b0; started = 1'b0;
    for (int i = 0; i < 64; i++) begin
      res_tab[i]   = 33'(i * 3);
      raise_tab[i] = '0;
    end
    cycle();
    started = 1'b1;
    cycle();
    check("rst_iss_ok", iss_ok, 1);
    check("rst_out_vld", out_vld, 0);
    rst = 1'b0;

    // Back-to-back issue with writeback always ready.
    log_tag.delete(); log_res.delete();
    first_vld_cyc = -1; seen_ok_low = 1'b0; iss0 = cyc;
    for (int t = 0; t < 8; t++) drive(1'b1, t, 1'b1);
    for (int i = 0; i < 6; i++) drive(1'b0, 0, 1'b1);
    check("issue_to_vld", first_vld_cyc - iss0, LAT + 1);
    check("t1_ok_low", seen_ok_low, 0);
    check("t1_count", log_tag.size(), 8);
    for (int i = 0; i < 8 && i < log_tag.size(); i++) begin
      check("t1_tag", log_tag[i], i);
      check("t1_res", log_res[i], i * 3);
    end

    // Stalled writeback: credit limits acceptance to DEPTH ops.
    log_tag.delete(); log_res.delete(); acc = 0;
    for (int i = 0; i < 8; i++) begin
      if (m_ok()) begin
        drive(1'b1, 10 + acc, 1'b0);
        acc++;
      end else begin
        drive(1'b0, 0, 1'b0);
      end
    end
    check("t2_accepted", acc, 4);
    check("t2_iss_ok_low", iss_ok, 0);
    check("t2_err", err_ovf, 0);
    for (int i = 0; i < 6; i++) drive(1'b0, 0, 1'b1);
    check("t2_count", log_tag.size(), 4);
    for (int i = 0; i < 4 && i < log_tag.size(); i++) check("t2_tag", log_tag[i], 10 + i);

    // Forced issue while credit is exhausted is dropped and flagged.
    log_tag.delete(); log_res.delete(); acc = 0;
    for (int i = 0; i < 8; i++) begin
      if (m_ok()) begin
        drive(1'b1, 20 + acc, 1'b0);
        acc++;
      end else begin
        drive(1'b0, 0, 1'b0);
      end
    end
    drive(1'b1, 50, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b0, 0, 1'b0);
    check("t3_err_set", err_ovf, 1);
    for (int i = 0; i < 6; i++) drive(1'b0, 0, 1'b1);
    hits = 0;
    foreach (log_tag[i]) if (log_tag[i] == 50) hits++;
    check("t3_dropped_absent", hits, 0);
    check("t3_drained", log_tag.size(), 4);
    check("t3_err_persist", err_ovf, 1);
    rst = 1'b1;
    drive(1'b0, 0, 1'b0);
    rst = 1'b0;
    check("t3_err_rst", err_ovf, 0);

    // Sticky accumulation and trap qualification.
    raise_tab[30] = 11'(1 << ExcInexact);
    raise_tab[31] = 11'(1 << ExcOver);
    raise_tab[32] = 11'(1 << ExcUnder);
    drive(1'b1, 30, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b0, 0, 1'b0);
    check("t4_sticky_inx", sticky, 11'(1 << ExcInexact));
    check("t4_head30", out_tag, 30);
    check("t4_trap_masked", out_trap, 0);
    exc_mask = 11'(1 << ExcOver);
    #1;
    check("t4_trap_other", out_trap, 0);
    drive(1'b1, 31, 1'b1);
    for (int i = 0; i < 3; i++) drive(1'b0, 0, 1'b0);
    check("t4_head31", out_tag, 31);
    check("t4_trap_over", out_trap, 1);
    check("t4_sticky_both", sticky, 11'((1 << ExcInexact) | (1 << ExcOver)));

    // Clear in the capture cycle keeps only the newly raised flag.
    drive(1'b1, 32, 1'b1);
    for (int i = 0; i < LAT - 1; i++) drive(1'b0, 0, 1'b1);
    sticky_clr = 1'b1;
    drive(1'b0, 0, 1'b1);
    sticky_clr = 1'b0;
    check("t5_sticky_under", sticky, 11'(1 << ExcUnder));
    for (int i = 0; i < 3; i++) drive(1'b0, 0, 1'b1);

    // Reset with two queued and two in flight.
    raise_tab[40] = 11'(1 << ExcInvalid);
    exc_mask = '0;
    drive(1'b1, 40, 1'b0);
    drive(1'b1, 41, 1'b0);
    for (int i = 0; i < LAT; i++) drive(1'b0, 0, 1'b0);
    drive(1'b1, 42, 1'b0);
    drive(1'b1, 43, 1'b0);
    check("t6_queued", out_tag, 40);
    rst = 1'b1;
    drive(1'b0, 0, 1'b1);
    rst = 1'b0;
    check("t6_vld", out_vld, 0);
    check("t6_iss_ok", iss_ok, 1);
    check("t6_sticky", sticky, 0);
    log_tag.delete(); log_res.delete();
    for (int i = 0; i < 5; i++) drive(1'b0, 0, 1'b1);
    check("t6_nothing_out", log_tag.size(), 0);
    check("t6_sticky_after", sticky, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
